// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel strobe divider, h/v counters and registered decode.
// Optional VGA_PREFETCH_EN adds a one-pixel-early coordinate request for lookups.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        pix_en,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        Hsynq,
    output logic        Vsynq,
    output logic        active,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        line_start,
`ifdef VGA_PREFETCH_EN
    output logic        frame_start,
    output logic        req_valid,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y
`else
    output logic        frame_start
`endif
);

    localparam int unsigned CW      = 16;
    localparam int unsigned PW      = 10;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned V_END   = V_START + V_ACTIVE;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             step;
    logic             h_wrap;
    logic             v_wrap;
    logic [CW-1:0]    h_nxt;
    logic [CW-1:0]    v_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             act_h;
    logic             act_v;
    logic             act_nxt;
    logic [PW-1:0]    px_nxt;
    logic [PW-1:0]    py_nxt;
    logic             ls_nxt;
    logic             fs_nxt;
`ifdef VGA_PREFETCH_EN
    logic [CW-1:0]    h_ahead;
    logic             rv_nxt;
    logic [PW-1:0]    rx_nxt;
    logic [PW-1:0]    ry_nxt;
`endif

    // Next-state counters and decode; outputs are registered from these so they
    // describe the same pixel as the counts in every clock.
    always_comb begin
        div_nxt = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        step    = (div_nxt == DIV_W'(CLK_DIV - 1));
        h_wrap  = (h_count == CW'(H_TOTAL - 1));
        v_wrap  = (v_count == CW'(V_TOTAL - 1));
        h_nxt   = h_count;
        v_nxt   = v_count;
        if (step) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? '0 : v_count + CW'(1);
            end else begin
                h_nxt = h_count + CW'(1);
            end
        end
        hs_nxt  = (h_nxt < CW'(H_SYNC));
        vs_nxt  = (v_nxt < CW'(V_SYNC));
        act_h   = (h_nxt >= CW'(H_START)) && (h_nxt < CW'(H_END));
        act_v   = (v_nxt >= CW'(V_START)) && (v_nxt < CW'(V_END));
        act_nxt = act_h && act_v;
        px_nxt  = '0;
        py_nxt  = '0;
        if (act_nxt) begin
            px_nxt = PW'(h_nxt - CW'(H_START));
            py_nxt = PW'(v_nxt - CW'(V_START));
        end
        ls_nxt  = step && h_wrap;
        fs_nxt  = step && h_wrap && v_wrap;
`ifdef VGA_PREFETCH_EN
        // The request looks one pixel ahead on the same line.
        h_ahead = h_nxt + CW'(1);
        rv_nxt  = (h_ahead >= CW'(H_START)) && (h_ahead < CW'(H_END)) && act_v;
        rx_nxt  = '0;
        ry_nxt  = '0;
        if (rv_nxt) begin
            rx_nxt = PW'(h_ahead - CW'(H_START));
            ry_nxt = PW'(v_nxt - CW'(V_START));
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            Hsynq       <= 1'b1;
            Vsynq       <= 1'b1;
            active      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            pix_en      <= step;
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            Hsynq       <= hs_nxt;
            Vsynq       <= vs_nxt;
            active      <= act_nxt;
            pix_x       <= px_nxt;
            pix_y       <= py_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

`ifdef VGA_PREFETCH_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_valid <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
        end else begin
            req_valid <= rv_nxt;
            req_x     <= rx_nxt;
            req_y     <= ry_nxt;
        end
    end
`endif

endmodule
